// File: rtl/sel_pipe_mux.sv
// N-input registered select stage with valid/ready handshake and one skid entry; optional SEL_PIPE_MUX_PARITY_EN adds out_parity.
// Latency 1 cycle; in_ready is registered (skid empty) and never depends combinationally on out_ready.
module sel_pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
`ifdef SEL_PIPE_MUX_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [SEL_W-1:0] sel;
`ifdef SEL_PIPE_MUX_PARITY_EN
        logic             par;
`endif
    } beat_t;

    state_t state, state_nxt;
    beat_t  cap, main_q, skid_q;
    logic   cap_hit;
    logic   ld_main_cap, ld_main_skid, ld_skid;
    logic   accept;

    // Out-of-range selects match no input, leaving the captured data at zero.
    always_comb begin
        cap     = '0;
        cap_hit = 1'b0;
        cap.sel = in_sel;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                cap.dat = in_data[i*WIDTH +: WIDTH];
                cap_hit = 1'b1;
            end
        end
`ifdef SEL_PIPE_MUX_PARITY_EN
        cap.par = ^cap.dat;
`endif
    end

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt    = state;
        ld_main_cap  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    ld_main_cap = 1'b1;
                    state_nxt   = ONE;
                end
            end
            ONE: begin
                if (in_valid && out_ready) begin
                    ld_main_cap = 1'b1;
                end else if (in_valid) begin
                    ld_skid   = 1'b1;
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    ld_main_skid = 1'b1;
                    state_nxt    = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            sel_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_main_cap) begin
                main_q <= cap;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= cap;
            end
            if (accept && !cap_hit) begin
                sel_err <= 1'b1;
            end
        end
    end

    assign out_data = main_q.dat;
    assign out_sel  = main_q.sel;
`ifdef SEL_PIPE_MUX_PARITY_EN
    assign out_parity = main_q.par;
`endif

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Scoreboard bench for sel_pipe_mux (WIDTH=32, NUM_IN=3, SEL_W=2); checks handshake, ordering, sel_err and reset.
module tb_sel_pipe_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;
`ifdef SEL_PIPE_MUX_PARITY_EN
    logic        out_parity;
`endif

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t q[$];
    logic err_m;
    int   n_chk  = 0;
    int   n_pass = 0;

    sel_pipe_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
`ifdef SEL_PIPE_MUX_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input logic [95:0] d, input logic [1:0] s);
        exp_t e;
        e.s = s;
        case (s)
            2'd0:    e.d = d[31:0];
            2'd1:    e.d = d[63:32];
            2'd2:    e.d = d[95:64];
            default: e.d = 32'h0;
        endcase
        return e;
    endfunction

    // Inputs are already applied; compare at the falling edge, then advance one rising edge.
    task automatic step();
        int   occ;
        exp_t e;
        @(negedge clk);
        occ = q.size();
        chk("in_ready", 64'(in_ready), 64'(occ < 2));
        chk("out_valid", 64'(out_valid), 64'(occ != 0));
        chk("sel_err", 64'(sel_err), 64'(err_m));
        if (out_valid && occ != 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_sel", 64'(out_sel), 64'(q[0].s));
`ifdef SEL_PIPE_MUX_PARITY_EN
            chk("out_parity", 64'(out_parity), 64'(^q[0].d));
`endif
            if (out_ready) void'(q.pop_front());
        end
        if (in_valid && occ < 2) begin
            e = model(in_data, in_sel);
            q.push_back(e);
            if (in_sel > 2'd2) err_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic ordy);
        in_valid  = v;
        in_sel    = s;
        out_ready = ordy;
        step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_sel_err"}, 64'(sel_err), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_sel"}, 64'(out_sel), 64'd0);
`ifdef SEL_PIPE_MUX_PARITY_EN
        chk({tag, "_out_parity"}, 64'(out_parity), 64'd0);
`endif
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_m     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single beat, then streaming at full rate
        in_data = {32'h3, 32'h2, 32'h1};
        drive(1'b1, 2'd1, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        foreach (q[i]) chk("first_beat_sel", 64'(q[i].s), 64'd1);
        drive(1'b1, 2'd0, 1'b1);
        drive(1'b1, 2'd1, 1'b1);
        drive(1'b1, 2'd2, 1'b1);
        drive(1'b1, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);

        // back-pressure: fill main and skid, attempt a third, then drain
        drive(1'b1, 2'd0, 1'b0);
        drive(1'b1, 2'd2, 1'b0);
        drive(1'b1, 2'd1, 1'b0);
        drive(1'b1, 2'd1, 1'b0);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);

        // out-of-range select then a legal beat; sel_err is sticky
        drive(1'b1, 2'd3, 1'b1);
        drive(1'b1, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);

        // parity patterns: odd-weight 7, even-weight 3
        in_data = {32'h3, 32'h7, 32'h1};
        drive(1'b1, 2'd1, 1'b1);
        drive(1'b1, 2'd2, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);

        // fill to FULL, then reset mid-cycle
        drive(1'b1, 2'd0, 1'b0);
        drive(1'b1, 2'd1, 1'b0);
        drive(1'b1, 2'd2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("midrst");
        q.delete();
        err_m    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1);

        // random traffic with random back-pressure
        for (int n = 0; n < 400; n++) begin
            in_data = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) in_data[63:32] = 32'h7;
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 4; n++) drive(1'b0, 2'd0, 1'b1);
        chk("drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sel_pipe_mux.md
Name: sel_pipe_mux

Overview:
- Parametrised N-input, WIDTH-bit select stage, registered, with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the combinational 2:1/3:1 operand muxes where the selected operand must be pipelined and back-pressured, e.g. the EX-stage forwarding select feeding a multi-cycle unit.
- Flags out-of-range selects instead of silently substituting a value.

Parameters:
- WIDTH, 32: data width per input.
- NUM_IN, 3: number of data inputs; legal range 2..16.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select for the current beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- out_data  out  WIDTH  selected, registered data.
- out_sel  out  SEL_W  select value that produced out_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  sticky; set on any accepted beat with in_sel >= NUM_IN.

Behaviour:
- Reset (async assert, sync release internally not required): out_data=0, out_sel=0, out_valid=0, in_ready=1, sel_err=0. Both skid entries are invalidated.
- Accept rule: a beat transfers in when in_valid && in_ready at a rising clk. A beat transfers out when out_valid && out_ready.
- Selection: an accepted beat stores in_data[in_sel*WIDTH +: WIDTH] and in_sel.
  - If in_sel >= NUM_IN: stored data is 0, stored out_sel = in_sel, and sel_err is set on that edge.
  - sel_err clears only on reset.
- Latency: 1 cycle. A beat accepted at edge k is presented on out_* after edge k when the output register is free.
- Storage: output register (main) plus one skid register.
- in_ready is registered and equals "skid entry empty". in_ready never depends combinationally on out_ready.
- State machine, by occupancy:
  - EMPTY (main invalid): accept loads main → ONE.
  - ONE (main valid, skid empty):
    - accept and no drain: load skid → FULL.
    - accept and drain: load main → stays ONE.
    - drain only → EMPTY.
    - neither: hold.
  - FULL (both valid, in_ready=0): drain moves skid into main → ONE. No accept is possible.
- Ordering: beats exit in acceptance order; no beat is dropped or duplicated.
- Hold: while out_valid && !out_ready, out_data and out_sel are stable.
- Simultaneous accept and drain in ONE: output updates to the new beat on the same edge. Throughput is 1 beat/cycle with out_ready held high.
- in_data and in_sel are ignored when in_valid=0.
- Reset mid-transfer: all buffered beats are discarded; no out_valid pulse follows reset.
- WIDTH=1 and NUM_IN=2**SEL_W are legal. With NUM_IN=2**SEL_W, sel_err can never set.

Optional Feature:
- Macro: SEL_PIPE_MUX_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit) = XOR reduction of the stored out_data.
  - out_parity is computed at capture, registered with the beat, travels through the skid register, and resets to 0.
  - A zero-substituted out-of-range beat has out_parity=0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then WIDTH=32, NUM_IN=3, in_data={32'h3,32'h2,32'h1}. Apply in_sel=1, in_valid=1, out_ready=1 for 1 cycle → next cycle out_valid=1, out_data=32'h2, out_sel=1, sel_err=0.
- out_ready=1, inputs streaming sel 0,1,2,0 on consecutive cycles → out_data 1,2,3,1 on consecutive cycles, in_ready constantly 1.
- out_ready=0, push beats sel=0 then sel=2 → after the 2nd accept in_ready=0 and out_data=32'h1 held. Raise out_ready → 32'h1 then 32'h3 exit in order, and in_ready returns to 1.
- in_sel=3 (NUM_IN=3) accepted → out_data=0, out_sel=3, sel_err=1. A later sel=0 beat gives out_data=32'h1 and sel_err stays 1.
- Fill to FULL (out_ready=0), assert reset for 1 cycle mid-clock → out_valid=0, in_ready=1, sel_err=0 immediately, with no stale beats after release.
- With SEL_PIPE_MUX_PARITY_EN: select input 32'h7 → out_parity=1. Select input 32'h3 → out_parity=0.
